// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter.
// The response struct carries the control half of the registered response stage.
package mem_arb_pkg;

    localparam int MEM_AW    = 12;
    localparam int MEM_DW    = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int RSP_IDW   = 3;

    typedef logic [MEM_AW-1:0] mem_addr_t;
    typedef logic [MEM_DW-1:0] mem_data_t;

    typedef struct packed {
        logic               valid;
        logic [RSP_IDW-1:0] id;
        logic               we;
        logic               err;
    } rsp_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: grants the first requester at or after ptr, modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Pick the requester with the smallest rotated distance from ptr.
    always_comb begin
        int best;
        int d;
        best = N;
        d    = 0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + N;
            if (req[i] && d < best) begin
                best = d;
                idx  = IW'(i);
            end
        end
    end

    assign any = |req;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++)
            gnt[i] = any && (idx == IW'(i));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NREQ requesters with round-robin arbitration;
// drives the port combinationally and returns a tagged response one cycle later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int DEPTH = MEM_DEPTH,
    parameter int IDW   = RSP_IDW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_we,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_data,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    logic [NREQ-1:0] vld_g;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic            any;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;
    logic            in_range;
    rsp_t            rsp_q;

    // No grants while reset is held, so nothing can be accepted or driven.
    assign vld_g = req_valid & {NREQ{rst_n}};

    rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .req (vld_g),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_we    = req_we[i];
            end
        end
    end

    assign in_range = (32'(sel_addr) < DEPTH);

    // Out-of-range requests never reach the memory port.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (any && in_range) begin
            mem_we   = sel_we;
            mem_addr = sel_addr;
            if (sel_we) mem_din = sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            rsp_q <= '0;
        end else begin
            if (any) begin
                ptr   <= (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
                rsp_q <= '{valid: 1'b1, id: RSP_IDW'(gidx), we: sel_we, err: ~in_range};
            end else begin
                rsp_q <= '0;
            end
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_id    = IDW'(rsp_q.id);
    assign rsp_we    = rsp_q.we;
    assign rsp_err   = rsp_q.err;
    // Memory registers the read itself, so dout lines up with the response cycle.
    assign rsp_data  = (rsp_q.valid && !rsp_q.we && !rsp_q.err) ? mem_dout : '0;

endmodule
